// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM state type and add/sub mode encodings
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_unit_bit_cell.sv
// serial_bit_cell: one-bit full adder/subtractor (i_a,i_b,i_c,i_mode -> o_r sum/diff, o_c carry/borrow out)
module serial_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_mode,
  output logic o_r,
  output logic o_c
);
  logic w_a;
  assign w_a = i_mode == MODE_SUB ? ~i_a : i_a;
  assign o_r = i_a ^ i_b ^ i_c;
  assign o_c = (w_a & i_b) | (w_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial LSB-first A+/-B (in: CLK,RST,St,Mode,A_in,B_in; out: Busy,Done,Result,Co,Ovf; Ovf live only with SERIAL_ADDSUB_OVF_EN)
module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         St,
  input  logic         Mode,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Result,
  output logic         Co,
  output logic         Ovf
);
  state_t r_state, w_next;
  logic [N-1:0] r_acc, r_addend;
  logic [CW-1:0] r_cnt;
  logic r_mode, r_c, r_co, w_r, w_c, w_last;
  serial_bit_cell u_cell (
    .i_a(r_acc[0]),
    .i_b(r_addend[0]),
    .i_c(r_c),
    .i_mode(r_mode),
    .o_r(w_r),
    .o_c(w_c)
  );
  assign w_last = r_cnt == CW'(N - 1);
  always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE  ? (St ? SHIFT : IDLE) :
             r_state == SHIFT ? (w_last ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    Busy = r_state == SHIFT;
    Done = r_state == DONE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc    <= '0;
      r_addend <= '0;
      r_mode   <= MODE_ADD;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_co     <= 1'b0;
    end else if (r_state == IDLE && St) begin
      r_acc    <= A_in;
      r_addend <= B_in;
      r_mode   <= Mode;
      r_c      <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == SHIFT) begin
      r_acc    <= {w_r, r_acc[N-1:1]};
      r_addend <= {r_addend[0], r_addend[N-1:1]};
      r_c      <= w_c;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_co <= w_c;
    end
  end
  assign Result = r_acc;
  assign Co     = r_co;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;
  always_ff @(posedge CLK) begin
    if (RST) r_ovf <= 1'b0;
    else if (r_state == SHIFT && w_last) r_ovf <= r_c ^ w_c;
  end
  assign Ovf = r_ovf;
`else
  assign Ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb_serial_addsub_unit: directed and randomized checks of serial_addsub_unit against an arithmetic model
module tb_serial_addsub_unit;
  import serial_addsub_pkg::*;
  localparam int N = 8;
  logic CLK = 1'b0, RST = 1'b1, St = 1'b0, Mode = 1'b0;
  logic [N-1:0] A_in = '0, B_in = '0, Result;
  logic Busy, Done, Co, Ovf;
  int n_tests = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  serial_addsub_unit #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .St(St), .Mode(Mode), .A_in(A_in), .B_in(B_in),
    .Busy(Busy), .Done(Done), .Result(Result), .Co(Co), .Ovf(Ovf)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N+1:0] model(input logic m, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    logic ov;
    s  = m ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    ov = m ? (a[N-1] != b[N-1] && s[N-1] != a[N-1]) : (a[N-1] == b[N-1] && s[N-1] != a[N-1]);
`ifndef SERIAL_ADDSUB_OVF_EN
    ov = 1'b0;
`endif
    return {ov, s[N], s[N-1:0]};
  endfunction
  task automatic finish_op(input bit hold, input logic m, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic nm, input logic [N-1:0] na, input logic [N-1:0] nb);
    int cyc;
    logic [N+1:0] e;
    e = model(m, a, b);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        check("busy", Busy, 1);
        if (!hold) St = 1'b0;
        Mode = nm;
        A_in = na;
        B_in = nb;
      end
    end while (!Done && cyc < N + 4);
    check("latency", cyc, N + 1);
    check("result", Result, e[N-1:0]);
    check("co", Co, e[N]);
    check("ovf", Ovf, e[N+1]);
    check("addend", dut.r_addend, b);
    check("busy_at_done", Busy, 0);
    @(negedge CLK);
    check("done_pulse", Done, 0);
    check("held_result", Result, e[N-1:0]);
  endtask
  task automatic run_op(input logic m, input logic [N-1:0] a, input logic [N-1:0] b);
    St = 1'b1;
    Mode = m;
    A_in = a;
    B_in = b;
    finish_op(1'b0, m, a, b, 1'($urandom), N'($urandom), N'($urandom));
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int seen;
    repeat (3) @(negedge CLK);
    check("rst_result", Result, 0);
    check("rst_co", Co, 0);
    check("rst_ovf", Ovf, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_done", Done, 0);
    run_op(1'b1, 8'h5A, 8'h3C);
    check("sub_5a_3c", Result, 8'h1E);
    run_op(1'b1, 8'h10, 8'h20);
    check("sub_borrow", Co, 1);
    run_op(1'b0, 8'hFF, 8'h01);
    check("add_wrap", Result, 8'h00);
    run_op(1'b0, 8'h7F, 8'h01);
    check("add_7f", Result, 8'h80);
    St = 1'b1;
    Mode = 1'b0;
    A_in = 8'h12;
    B_in = 8'h34;
    finish_op(1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 8'h55, 8'h0F);
    finish_op(1'b0, 1'b1, 8'h55, 8'h0F, 1'b0, 8'h00, 8'h00);
    St = 1'b1;
    Mode = 1'b0;
    A_in = 8'hA5;
    B_in = 8'h3B;
    @(negedge CLK);
    St = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_result", Result, 0);
    check("mid_rst_co", Co, 0);
    check("mid_rst_ovf", Ovf, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_state", dut.r_state, IDLE);
    RST = 1'b0;
    seen = 0;
    repeat (N + 3) begin
      @(negedge CLK);
      if (Done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    run_op(1'b0, 8'hA5, 8'h3B);
    for (int i = 0; i < 300; i++) run_op(1'($urandom), N'($urandom), N'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
